// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO (shift-add multiply, restoring divide).
// Define MULDIV_MADD_EN to enable the MADD/MADDU accumulate ops (100/101).
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;       // multiply: {partial, multiplier}; divide: {remainder, quotient}
   logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
   logic [WIDTH-1:0]   op1_raw;
   logic               is_div, neg_q, neg_r, zero_div;
`ifdef MULDIV_MADD_EN
   logic               is_madd;
`endif

   logic               op_legal, start_ok, op_signed, op_is_div;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] step_val, prod_s, res_mul, res_div, res;
   logic [WIDTH-1:0]   q_s, r_s;

   always_comb begin
      op_legal = 1'b0;
      case (i_op)
         3'b000, 3'b001, 3'b010, 3'b011: op_legal = 1'b1;
`ifdef MULDIV_MADD_EN
         3'b100, 3'b101:                 op_legal = 1'b1;
`endif
         default:                        op_legal = 1'b0;
      endcase
   end

   assign start_ok  = (state == S_IDLE) && i_start && op_legal;
   assign op_signed = ~i_op[0];
   assign op_is_div = (i_op[2:1] == 2'b01);
   assign mag1      = (op_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
   assign mag2      = (op_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_CALC;
         S_CALC:  if (count == CW'(1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // One iteration: multiply adds the multiplicand when the multiplier LSB is set, then shifts
   // right; divide shifts the remainder left and subtracts the divisor when it fits.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_shift >= {1'b0, opnd});
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      if (is_div)
         step_val = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
      else
         step_val = {mul_sum, acc[WIDTH-1:1]};
   end

   always_comb begin
      prod_s = neg_q ? -acc : acc;
`ifdef MULDIV_MADD_EN
      res_mul = is_madd ? ({o_hi, o_lo} + prod_s) : prod_s;
`else
      res_mul = prod_s;
`endif
      q_s     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      r_s     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_div = zero_div ? {op1_raw, {WIDTH{1'b1}}} : {r_s, q_s};
      res     = is_div ? res_div : res_mul;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count      <= '0;
         acc        <= '0;
         opnd       <= '0;
         op1_raw    <= '0;
         is_div     <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         zero_div   <= 1'b0;
`ifdef MULDIV_MADD_EN
         is_madd    <= 1'b0;
`endif
         o_hi       <= '0;
         o_lo       <= '0;
         o_done     <= 1'b0;
         o_div_zero <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  count    <= CW'(WIDTH);
                  is_div   <= op_is_div;
`ifdef MULDIV_MADD_EN
                  is_madd  <= i_op[2];
`endif
                  neg_q    <= op_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                  neg_r    <= op_signed & i_op1[WIDTH-1];
                  zero_div <= (i_op2 == '0);
                  op1_raw  <= i_op1;
                  opnd     <= op_is_div ? mag2 : mag1;
                  acc      <= {{WIDTH{1'b0}}, (op_is_div ? mag1 : mag2)};
               end else begin
                  if (i_hi_we) o_hi <= i_wdata;
                  if (i_lo_we) o_lo <= i_wdata;
               end
            end
            S_CALC: begin
               acc   <= step_val;
               count <= count - CW'(1);
            end
            S_FIX: begin
               {o_hi, o_lo} <= res;
               o_done       <= 1'b1;
               o_div_zero   <= is_div & zero_div;
            end
            default: ;
         endcase
      end
   end

   assign o_busy      = (state != S_IDLE);
   assign o_dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of hand-computed results plus corner sequences.
module tb_muldiv_unit;
   localparam int W   = 32;
   localparam int LAT = W + 1;
   localparam int NV  = 14;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MADD  = 3'b100;
   localparam logic [2:0] OP_MADDU = 3'b101;

   logic         i_clk = 1'b0;
   logic         i_rst, i_start, i_hi_we, i_lo_we;
   logic [2:0]   i_op;
   logic [W-1:0] i_op1, i_op2, i_wdata;
   logic [W-1:0] o_hi, o_lo;
   logic         o_busy, o_done, o_div_zero;
   logic [1:0]   o_dbg_state;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b;
      logic [W-1:0] hi, lo;
      logic         chk_dz;
      logic         dz;
   } vec_t;

   vec_t vecs[NV];

   muldiv_unit #(.WIDTH(W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
      .i_op1(i_op1), .i_op2(i_op2), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
      .i_wdata(i_wdata), .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy),
      .o_done(o_done), .o_div_zero(o_div_zero), .o_dbg_state(o_dbg_state)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic mt_write(input logic hi_we, input logic lo_we, input logic [W-1:0] d);
      i_hi_we = hi_we; i_lo_we = lo_we; i_wdata = d;
      tick();
      i_hi_we = 1'b0; i_lo_we = 1'b0;
   endtask

   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      i_start = 1'b1; i_op = op; i_op1 = a; i_op2 = b;
      tick();
      i_start = 1'b0;
   endtask

   // Edges counted from the accepting edge until o_done is seen (bounded).
   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      while (!o_done && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   task automatic count_done(input int n, output int dn);
      dn = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (o_done) dn++;
      end
   endtask

   initial begin
      int cyc, dn;
      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0, 1'b0};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0};
      vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
      vecs[4]  = '{OP_DIVU,  32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF, 1'b1, 1'b1};
      vecs[5]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b1, 1'b0};
      vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b1, 1'b0};
      vecs[7]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
      vecs[8]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
      vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
      vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b1};
      vecs[11] = '{OP_MULT,  32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0, 1'b0};
      vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[13] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b1, 1'b0};

      i_rst = 1'b1; i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
      i_op = 3'b000; i_op1 = '0; i_op2 = '0; i_wdata = '0;
      tick(); tick();
      i_rst = 1'b0;
      check("rst_hi", o_hi, '0);
      check("rst_lo", o_lo, '0);
      check("rst_busy", W'(o_busy), '0);
      check("rst_done", W'(o_done), '0);
      check("rst_dz", W'(o_div_zero), '0);

      // MTHI/MTLO, both together, then separately
      mt_write(1'b1, 1'b1, 32'hA5A5A5A5);
      check("mt_both_hi", o_hi, 32'hA5A5A5A5);
      check("mt_both_lo", o_lo, 32'hA5A5A5A5);
      mt_write(1'b0, 1'b1, 32'h0000BEEF);
      check("mtlo_hi", o_hi, 32'hA5A5A5A5);
      check("mtlo_lo", o_lo, 32'h0000BEEF);

      for (int i = 0; i < NV; i++) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d_busy", i), W'(o_busy), 32'd1);
         wait_done(0, cyc);
         check($sformatf("v%0d_lat", i), W'(cyc), W'(LAT));
         check($sformatf("v%0d_hi", i), o_hi, vecs[i].hi);
         check($sformatf("v%0d_lo", i), o_lo, vecs[i].lo);
         check($sformatf("v%0d_idle", i), W'(o_busy), '0);
         if (vecs[i].chk_dz) check($sformatf("v%0d_dz", i), W'(o_div_zero), W'(vecs[i].dz));
         tick();
         check($sformatf("v%0d_pulse", i), W'(o_done), '0);
      end

      // Divide-by-zero flag holds until the next completion
      start_op(OP_DIVU, 32'd10, 32'd0);
      wait_done(0, cyc);
      check("dz_set", W'(o_div_zero), 32'd1);
      for (int k = 0; k < 4; k++) tick();
      mt_write(1'b1, 1'b0, 32'h00000123);
      check("dz_hold_idle", W'(o_div_zero), 32'd1);
      start_op(OP_DIV, 32'd9, 32'd3);
      for (int k = 0; k < 5; k++) tick();
      check("dz_hold_calc", W'(o_div_zero), 32'd1);
      wait_done(6, cyc);
      check("dz_clear", W'(o_div_zero), '0);
      check("dz_clear_lo", o_lo, 32'd3);

      // Start with write strobes in the same cycle: write dropped
      mt_write(1'b1, 1'b1, 32'h77777777);
      i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h0000DEAD;
      start_op(OP_MULTU, 32'd2, 32'd3);
      i_hi_we = 1'b0; i_lo_we = 1'b0;
      check("sw_hi_kept", o_hi, 32'h77777777);
      check("sw_lo_kept", o_lo, 32'h77777777);
      wait_done(0, cyc);
      check("sw_lat", W'(cyc), W'(LAT));
      check("sw_lo", o_lo, 32'd6);

      // Second start and MTHI mid-CALC are ignored
      mt_write(1'b1, 1'b0, 32'h11111111);
      start_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
      for (int k = 0; k < 9; k++) tick();
      i_start = 1'b1; i_op = OP_DIVU; i_op1 = 32'd50; i_op2 = 32'd5;
      i_hi_we = 1'b1; i_wdata = 32'hDEADBEEF;
      tick();
      i_start = 1'b0; i_hi_we = 1'b0;
      check("mid_hi_hold", o_hi, 32'h11111111);
      check("mid_busy", W'(o_busy), 32'd1);
      wait_done(10, cyc);
      check("mid_lat", W'(cyc), W'(LAT));
      check("mid_hi", o_hi, 32'hFFFFFFFF);
      check("mid_lo", o_lo, 32'hFFFFFFF1);
      count_done(40, dn);
      check("mid_extra_done", W'(dn), '0);

      // Reset at edge E+10 of a MULT
      mt_write(1'b1, 1'b1, 32'h55555555);
      start_op(OP_MULT, 32'h00000007, 32'h00000009);
      for (int k = 0; k < 9; k++) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("rstmid_hi", o_hi, '0);
      check("rstmid_lo", o_lo, '0);
      check("rstmid_busy", W'(o_busy), '0);
      count_done(40, dn);
      check("rstmid_no_done", W'(dn), '0);

      // Back-to-back: next start accepted while o_done is high
      start_op(OP_MULTU, 32'd3, 32'd4);
      wait_done(0, cyc);
      check("b2b_first_lo", o_lo, 32'd12);
      start_op(OP_MULTU, 32'd5, 32'd6);
      check("b2b_accept", W'(o_busy), 32'd1);
      check("b2b_lo_hold", o_lo, 32'd12);
      wait_done(0, cyc);
      check("b2b_lat", W'(cyc), W'(LAT));
      check("b2b_second_lo", o_lo, 32'd30);

      // Illegal op 110: no effect
      mt_write(1'b1, 1'b1, 32'h0F0F0F0F);
      start_op(3'b110, 32'd3, 32'd3);
      check("ill_busy", W'(o_busy), '0);
      count_done(4, dn);
      check("ill_done", W'(dn), '0);
      check("ill_hi", o_hi, 32'h0F0F0F0F);

`ifdef MULDIV_MADD_EN
      mt_write(1'b1, 1'b0, 32'h00000001);
      mt_write(1'b0, 1'b1, 32'hFFFFFFFF);
      start_op(OP_MADDU, 32'd1, 32'd1);
      wait_done(0, cyc);
      check("maddu_lat", W'(cyc), W'(LAT));
      check("maddu_hi", o_hi, 32'h00000002);
      check("maddu_lo", o_lo, 32'h00000000);
      mt_write(1'b1, 1'b0, 32'h00000000);
      mt_write(1'b0, 1'b1, 32'h00000005);
      start_op(OP_MADD, 32'hFFFFFFFD, 32'd5);
      wait_done(0, cyc);
      check("madd_hi", o_hi, 32'hFFFFFFFF);
      check("madd_lo", o_lo, 32'hFFFFFFF6);
`else
      mt_write(1'b1, 1'b0, 32'h00000001);
      mt_write(1'b0, 1'b1, 32'hFFFFFFFF);
      start_op(OP_MADDU, 32'd1, 32'd1);
      check("maddu_off_busy", W'(o_busy), '0);
      count_done(4, dn);
      check("maddu_off_done", W'(dn), '0);
      check("maddu_off_hi", o_hi, 32'h00000001);
      check("maddu_off_lo", o_lo, 32'hFFFFFFFF);
      start_op(OP_MADD, 32'd2, 32'd2);
      check("madd_off_busy", W'(o_busy), '0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
